main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Backing-store responder on the memory side of the data cache.
- Serves the cache controller's refill requests (read miss → 128-bit block) and write-through stores (byte/half/word) with a fixed, parameterised access latency.
- Signals completion with a one-cycle ready pulse, which releases the processor stall.
- Sits below the cache/controller pair inside the data memory system, in place of a zero-latency array.

Parameters:
- ADDR_W, 12, byte-address width.
- DEPTH_WORDS, 1024, number of 32-bit words stored (2^(ADDR_W-2)).
- LATENCY, 4, cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- miss  input  1  cache miss indication from the cache controller.
- hit  input  1  cache hit indication; informational only, no effect on acceptance.
- re  input  2  read size: 00 none, 01 byte, 10 half, 11 word.
- we  input  2  write size, same encoding as re.
- Data_addr  input  ADDR_W  byte address.
- Wdata  input  32  store data, right-aligned.
- Rdata  output  128  refill block; word at block offset n on bits [32n+31:32n].
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is in flight (BUSY, DONE, COOL).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ready=0, busy=0, Rdata=0, counter=0.
  - All memory words cleared to 0.
  - Reset mid-transaction aborts it: no memory update, no ready pulse.
- States: IDLE, BUSY, DONE, COOL.
- IDLE, sampled on a rising edge:
  - we!=0 → accept a write. Writes take priority over reads when both are set.
  - Else re!=0 and miss=1 → accept a block read.
  - Else stay in IDLE.
  - On accept: latch op, size, Data_addr, Wdata; counter=LATENCY-1; go to BUSY.
- BUSY:
  - counter!=0 → counter decrements each cycle; inputs are ignored.
  - counter==0 → perform the access at this edge and go to DONE.
  - Read: Rdata <= the four words at latched addr[ADDR_W-1:4], offsets 0..3.
  - Write (latched addr only; inputs are not resampled):
    - Word size ignores addr[1:0].
    - Half size writes Wdata[15:0] to bytes {addr[1],0} and {addr[1],1}; addr[0] is ignored (aligned down).
    - Byte size writes Wdata[7:0] to byte addr[1:0].
    - Unselected bytes are unchanged.
- DONE: ready=1 for exactly this cycle, then go to COOL.
- COOL: ready=0, no accept; go to IDLE. This gives the requester one cycle to drop miss/we after ready.
- Latency:
  - Request accepted at edge E0; ready is high between edges E0+LATENCY and E0+LATENCY+1.
  - Next acceptance is possible no earlier than edge E0+LATENCY+2.
- Rdata:
  - Valid while ready=1.
  - Held until the next completed read; writes leave Rdata unchanged.
- Addressing and contents:
  - Addresses wrap modulo DEPTH_WORDS*4.
  - No out-of-range errors.
  - A store accepted while a matching block read is pending cannot occur, since requests are serialised.
- busy: high from the edge after acceptance through the COOL cycle.

Test Plan:
- After reset release, re=11, miss=1, addr=0x380 with memory all zero → ready pulses at E0+4, Rdata=0, busy=1 for 6 cycles.
- we=11, addr=0x380, Wdata=7, then a read miss at 0x380 → Rdata[31:0]=7, Rdata[127:32]=0.
- Byte writes of 11, 12, 13 to 0x381, 0x382, 0x383 after word 7, then read miss at 0x380 → Rdata[31:0]=0x0D0C0B07.
- Half write 0xBEEF at 0x386, then read 0x380 → Rdata[63:32]=0xBEEF0000; writing 0xBEEF at 0x387 gives the same result.
- Both re=11 and we=01 in IDLE → write performed, no Rdata change; with LATENCY=1, ready at E0+1.
- Assert reset during BUSY of a write (Wdata=5) → ready never pulses; a subsequent read of that address returns 0.

Source files
------------

// File: rtl/main_mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the backing-store responder (slave).
interface main_mem_responder_if #(
   parameter int ADDR_W = 12
);
   logic              miss;
   logic              hit;
   logic [1:0]        re;
   logic [1:0]        we;
   logic [ADDR_W-1:0] Data_addr;
   logic [31:0]       Wdata;
   logic [127:0]      Rdata;
   logic              ready;
   logic              busy;

   modport master (
      output miss, hit, re, we, Data_addr, Wdata,
      input  Rdata, ready, busy
   );

   modport slave (
      input  miss, hit, re, we, Data_addr, Wdata,
      output Rdata, ready, busy
   );
endinterface

// File: rtl/main_mem_responder.sv
// Backing store under the data cache: serialised block refills and byte/half/word stores,
// each completing LATENCY cycles after acceptance with a one-cycle ready pulse.
module main_mem_responder #(
   parameter int ADDR_W      = 12,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   main_mem_responder_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE, COOL} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          cnt;
   logic                op_wr;
   logic [1:0]          op_size;
   logic [ADDR_W-1:0]   op_addr;
   logic [31:0]         op_wdata;
   logic [127:0]        rdata_q;
   logic [31:0]         mem [DEPTH_WORDS];

   logic                acc_wr;
   logic                acc_rd;
   logic                access;
   logic [3:0]          be;
   logic [31:0]         wb;
   logic                unused_hit;

   assign unused_hit = bus.hit;
   assign bus.Rdata  = rdata_q;
   assign bus.ready  = (state == DONE);
   assign bus.busy   = (state != IDLE);

   always_comb begin
      acc_wr    = 1'b0;
      acc_rd    = 1'b0;
      access    = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            // A store wins over a refill when both are presented
            if (bus.we != 2'b00) begin
               acc_wr    = 1'b1;
               state_nxt = BUSY;
            end else if (bus.re != 2'b00 && bus.miss) begin
               acc_rd    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               access    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = COOL;
         COOL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Byte lanes and lane-replicated data for the latched store
   always_comb begin
      be = 4'b0000;
      wb = op_wdata;
      case (op_size)
         2'b11: be = 4'b1111;
         2'b10: begin
            be = op_addr[1] ? 4'b1100 : 4'b0011;
            wb = {2{op_wdata[15:0]}};
         end
         2'b01: begin
            be = 4'b0001 << op_addr[1:0];
            wb = {4{op_wdata[7:0]}};
         end
         default: be = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= 4'd0;
         op_wr    <= 1'b0;
         op_size  <= 2'b00;
         op_addr  <= '0;
         op_wdata <= 32'd0;
         rdata_q  <= 128'd0;
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= 32'd0;
         end
      end else begin
         if (acc_wr || acc_rd) begin
            op_wr    <= acc_wr;
            op_size  <= acc_wr ? bus.we : bus.re;
            op_addr  <= bus.Data_addr;
            op_wdata <= bus.Wdata;
            cnt      <= 4'(LATENCY - 1);
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         if (access) begin
            if (op_wr) begin
               for (int b = 0; b < 4; b++) begin
                  if (be[b]) begin
                     mem[op_addr[ADDR_W-1:2]][8*b +: 8] <= wb[8*b +: 8];
                  end
               end
            end else begin
               for (int n = 0; n < 4; n++) begin
                  rdata_q[32*n +: 32] <= mem[{op_addr[ADDR_W-1:4], 2'(n)}];
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboarded random bench for main_mem_responder against a byte-array reference memory.
module tb_main_mem_responder;
   localparam int LAT = 4;

   typedef struct {
      logic [127:0] rdata;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   main_mem_responder_if #(.ADDR_W(12)) bus ();
   main_mem_responder_if #(.ADDR_W(12)) bus1 ();

   main_mem_responder #(.ADDR_W(12), .DEPTH_WORDS(1024), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   main_mem_responder #(.ADDR_W(12), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   exp_t         sb [$];
   exp_t         mon_e;
   int           tests = 0;
   int           fails = 0;
   int           cyc = 0;
   logic [7:0]   ref_mem [4096];
   logic [127:0] last_rd;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] ref_block(input logic [11:0] a);
      logic [127:0] r;
      logic [11:0]  base;
      base = {a[11:4], 4'h0};
      for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_mem[base + k];
      return r;
   endfunction

   function automatic void ref_write(input logic [1:0] size, input logic [11:0] a, input logic [31:0] d);
      case (size)
         2'b11: for (int k = 0; k < 4; k++) ref_mem[{a[11:2], 2'b00} + k] = d[8*k +: 8];
         2'b10: begin
            ref_mem[{a[11:1], 1'b0}]     = d[7:0];
            ref_mem[{a[11:1], 1'b0} + 1] = d[15:8];
         end
         2'b01: ref_mem[a] = d[7:0];
         default: ;
      endcase
   endfunction

   function automatic void ref_clear();
      for (int k = 0; k < 4096; k++) ref_mem[k] = 8'h00;
      last_rd = 128'd0;
   endfunction

   // Present one request for a single cycle, then watch the busy window close
   task automatic issue(input logic [1:0] re, input logic [1:0] we, input logic miss,
                        input logic [11:0] a, input logic [31:0] d);
      bit   acc;
      exp_t e;
      int   n;
      @(negedge clk);
      bus.re = re; bus.we = we; bus.miss = miss; bus.hit = 1'($urandom_range(0, 1));
      bus.Data_addr = a; bus.Wdata = d;
      acc = (we != 2'b00) || (re != 2'b00 && miss);
      if (acc) begin
         if (we != 2'b00) ref_write(we, a, d);
         else last_rd = ref_block(a);
         e.rdata = last_rd;
         e.acc   = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.re = 2'b00; bus.we = 2'b00; bus.miss = 1'b0;
      bus.Data_addr = 12'($urandom); bus.Wdata = $urandom;
      n = 0;
      while (bus.busy && n < 64) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, acc ? LAT + 2 : 0);
   endtask

   always @(negedge clk) begin
      if (reset && bus.ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready: got ready=1, expected no pending request");
         end else begin
            mon_e = sb.pop_front();
            check("rdata", bus.Rdata, mon_e.rdata);
            check("latency", cyc - mon_e.acc, LAT);
            check("busy_at_ready", bus.busy, 1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      int          k;
      logic [11:0] a;
      logic [31:0] d;
      bus.re = 0; bus.we = 0; bus.miss = 0; bus.hit = 0; bus.Data_addr = 0; bus.Wdata = 0;
      bus1.re = 0; bus1.we = 0; bus1.miss = 0; bus1.hit = 0; bus1.Data_addr = 0; bus1.Wdata = 0;
      ref_clear();
      repeat (3) @(negedge clk);
      check("rst_ready", bus.ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rdata", bus.Rdata, 0);
      check("rst1_ready", bus1.ready, 0);
      reset = 1'b1;

      issue(2'b11, 2'b00, 1'b1, 12'h380, 32'h0);
      check("read_zero", bus.Rdata, 128'd0);
      issue(2'b00, 2'b11, 1'b0, 12'h380, 32'h7);
      issue(2'b11, 2'b00, 1'b1, 12'h380, 32'h0);
      check("word7", bus.Rdata, {96'd0, 32'h7});
      issue(2'b00, 2'b01, 1'b0, 12'h381, 32'd11);
      issue(2'b00, 2'b01, 1'b0, 12'h382, 32'd12);
      issue(2'b00, 2'b01, 1'b0, 12'h383, 32'd13);
      issue(2'b11, 2'b00, 1'b1, 12'h380, 32'h0);
      check("bytes", bus.Rdata[31:0], 32'h0D0C0B07);
      issue(2'b00, 2'b10, 1'b0, 12'h386, 32'hBEEF);
      issue(2'b11, 2'b00, 1'b1, 12'h380, 32'h0);
      check("half_386", bus.Rdata[63:32], 32'hBEEF0000);
      issue(2'b00, 2'b11, 1'b0, 12'h384, 32'h0);
      issue(2'b00, 2'b10, 1'b0, 12'h387, 32'h1234BEEF);
      issue(2'b11, 2'b00, 1'b1, 12'h380, 32'h0);
      check("half_387", bus.Rdata[63:32], 32'hBEEF0000);
      issue(2'b11, 2'b01, 1'b1, 12'h390, 32'hA5);
      check("rw_prio_keep", bus.Rdata[63:32], 32'hBEEF0000);
      issue(2'b01, 2'b00, 1'b1, 12'h390, 32'h0);
      check("rw_prio_byte", bus.Rdata[7:0], 8'hA5);
      issue(2'b11, 2'b00, 1'b0, 12'h380, 32'h0);

      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 9);
         a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(12'h300, 12'h3FF));
         d = $urandom;
         if (k < 4) issue(2'($urandom_range(1, 3)), 2'b00, 1'b1, a, d);
         else if (k < 9) issue(2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)),
                               1'($urandom_range(0, 1)), a, d);
         else issue(2'($urandom_range(1, 3)), 2'b00, 1'b0, a, d);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Abort a store mid-flight with reset; it must leave no trace
      @(negedge clk);
      bus.we = 2'b11; bus.Data_addr = 12'h200; bus.Wdata = 32'd5;
      @(negedge clk);
      bus.we = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      ref_clear();
      @(negedge clk);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_rdata", bus.Rdata, 0);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      issue(2'b11, 2'b00, 1'b1, 12'h200, 32'h0);
      check("aborted_write", bus.Rdata, 128'd0);

      // Single-cycle latency instance: write wins over read, ready one edge after accept
      @(negedge clk);
      bus1.re = 2'b11; bus1.we = 2'b01; bus1.miss = 1'b1; bus1.Data_addr = 12'h010; bus1.Wdata = 32'hAB;
      @(negedge clk);
      bus1.re = 2'b00; bus1.we = 2'b00; bus1.miss = 1'b0;
      check("l1_ready_early", bus1.ready, 0);
      @(negedge clk);
      check("l1_ready", bus1.ready, 1);
      check("l1_rdata_keep", bus1.Rdata, 128'd0);
      @(negedge clk);
      check("l1_ready_drop", bus1.ready, 0);
      repeat (2) @(negedge clk);
      bus1.re = 2'b11; bus1.miss = 1'b1; bus1.Data_addr = 12'h01C;
      @(negedge clk);
      bus1.re = 2'b00; bus1.miss = 1'b0;
      @(negedge clk);
      check("l1_read_ready", bus1.ready, 1);
      check("l1_read_rdata", bus1.Rdata, 128'hAB);
      repeat (3) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
